// File: rtl/regfile_writeback_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_writeback_arbiter_if                                                |
// | Result-source, issue and register-file write-port signals of the arbiter.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface regfile_writeback_arbiter_if #(
    parameter int PTR_W = 1
);
    logic        alu_valid;
    logic [4:0]  alu_wr;
    logic [31:0] alu_wd;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_wr;
    logic [31:0] lng_wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [31:0] pending;
    logic [PTR_W:0] fifo_count;
    logic        err_reissue;

    modport master (
        output alu_valid, alu_wr, alu_wd,
        output lng_valid, lng_wr, lng_wd,
        output issue_valid, issue_rd,
        input  lng_ready, rf_we, rf_wr, rf_wd, pending, fifo_count, err_reissue
    );

    modport slave (
        input  alu_valid, alu_wr, alu_wd,
        input  lng_valid, lng_wr, lng_wd,
        input  issue_valid, issue_rd,
        output lng_ready, rf_we, rf_wr, rf_wd, pending, fifo_count, err_reissue
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_writeback_arbiter                                                   |
// | Owns the register-file write port: ALU results first, queued long-latency  |
// | results otherwise, plus a pending-destination scoreboard for RAW checks.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    regfile_writeback_arbiter_if.slave         bus
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [4:0]       r_fifo_wr [DEPTH];
    logic [31:0]      r_fifo_wd [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_rf_we;
    logic [4:0]       r_rf_wr;
    logic [31:0]      r_rf_wd;
    logic [31:0]      r_pending;
    logic             r_err_reissue;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_sel_valid;
    logic [4:0]       w_sel_wr;
    logic [31:0]      w_sel_wd;
    logic [4:0]       w_head_wr;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_pending_nxt;
    logic             w_reissue;

    assign w_ready   = (r_count != c_DEPTH);
    assign w_push    = bus.lng_valid && w_ready;
    assign w_pop     = !bus.alu_valid && (r_count != '0);
    assign w_head_wr = r_fifo_wr[r_rd_ptr];

    // ALU can never stall, so it always wins the port; the FIFO only drains in idle ALU slots.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_wr    = 5'd0;
        w_sel_wd    = 32'd0;
        if (bus.alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_wr    = bus.alu_wr;
            w_sel_wd    = bus.alu_wd;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_wr    = w_head_wr;
            w_sel_wd    = r_fifo_wd[r_rd_ptr];
        end
    end

    // Scoreboard: OR-ing the set mask after clearing makes a same-index issue win over a pop.
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            w_set_mask = 32'd1 << bus.issue_rd;
        end
        if (w_pop) begin
            w_clr_mask = 32'd1 << w_head_wr;
        end
        w_pending_nxt      = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0]   = 1'b0;
    end

    assign w_reissue = bus.issue_valid && (bus.issue_rd != 5'd0) && r_pending[bus.issue_rd];

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr[r_wr_ptr] <= bus.lng_wr;
            r_fifo_wd[r_wr_ptr] <= bus.lng_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rf_we       <= 1'b0;
            r_rf_wr       <= 5'd0;
            r_rf_wd       <= 32'd0;
            r_pending     <= 32'd0;
            r_err_reissue <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A write to register 0 still consumes its slot, it just never reaches the file.
            r_rf_we       <= w_sel_valid && (w_sel_wr != 5'd0);
            r_rf_wr       <= w_sel_wr;
            r_rf_wd       <= w_sel_wd;
            r_pending     <= w_pending_nxt;
            r_err_reissue <= r_err_reissue | w_reissue;
        end
    end

    assign bus.lng_ready   = w_ready;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_wr       = r_rf_wr;
    assign bus.rf_wd       = r_rf_wd;
    assign bus.pending     = r_pending;
    assign bus.fifo_count  = r_count;
    assign bus.err_reissue = r_err_reissue;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_writeback_arbiter                                                |
// | Directed vector table plus hand-written reset sequence for the arbiter.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;
    localparam int NV    = 23;

    typedef struct {
        logic        av;
        logic [4:0]  aw;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lw;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ir;
        logic        ewe;
        logic [4:0]  ewr;
        logic [31:0] ewd;
        logic [31:0] epend;
        logic [1:0]  ecnt;
        logic        erdy;
        logic        eerr;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t tbl [NV];

    regfile_writeback_arbiter_if #(.PTR_W(PTR_W)) bus ();

    regfile_writeback_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic av, input logic [4:0] aw, input logic [31:0] ad,
        input logic lv, input logic [4:0] lw, input logic [31:0] ld,
        input logic iv, input logic [4:0] ir,
        input logic ewe, input logic [4:0] ewr, input logic [31:0] ewd,
        input logic [31:0] epend, input logic [1:0] ecnt, input logic erdy, input logic eerr);
        vec_t v;
        v.av = av; v.aw = aw; v.ad = ad;
        v.lv = lv; v.lw = lw; v.ld = ld;
        v.iv = iv; v.ir = ir;
        v.ewe = ewe; v.ewr = ewr; v.ewd = ewd;
        v.epend = epend; v.ecnt = ecnt; v.erdy = erdy; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.alu_valid   = v.av;
        bus.alu_wr      = v.aw;
        bus.alu_wd      = v.ad;
        bus.lng_valid   = v.lv;
        bus.lng_wr      = v.lw;
        bus.lng_wd      = v.ld;
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ir;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_wr      = 5'd0;
        bus.alu_wd      = 32'd0;
        bus.lng_valid   = 1'b0;
        bus.lng_wr      = 5'd0;
        bus.lng_wd      = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},      32'(bus.rf_we), 32'd0);
        chk({tag, "_wr"},      32'(bus.rf_wr), 32'd0);
        chk({tag, "_wd"},      bus.rf_wd, 32'd0);
        chk({tag, "_pending"}, bus.pending, 32'd0);
        chk({tag, "_count"},   32'(bus.fifo_count), 32'd0);
        chk({tag, "_err"},     32'(bus.err_reissue), 32'd0);
        chk({tag, "_ready"},   32'(bus.lng_ready), 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          av aw     ad            lv lw     ld         iv ir     ewe ewr    ewd           epend         cnt  rdy  err
        tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,     0, 5'd0,  1, 5'd5,  32'hDEADBEEF, 32'h0,        2'd0, 1, 0);
        tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     0, 5'd0,  0, 5'd0,  32'h0,        32'h0,        2'd0, 1, 0);
        tbl[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     1, 5'd9,  0, 5'd0,  32'h0,        32'h00000200, 2'd0, 1, 0);
        tbl[3]  = mk(0, 5'd0,  32'h0,        1, 5'd9, 32'h1234,  0, 5'd0,  0, 5'd0,  32'h0,        32'h00000200, 2'd1, 1, 0);
        tbl[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     0, 5'd0,  1, 5'd9,  32'h1234,     32'h0,        2'd0, 1, 0);
        // ALU starves the FIFO; third long result waits for lng_ready
        tbl[5]  = mk(1, 5'd10, 32'hA0,       1, 5'd1, 32'h11,    0, 5'd0,  1, 5'd10, 32'hA0,       32'h0,        2'd1, 1, 0);
        tbl[6]  = mk(1, 5'd11, 32'hA1,       1, 5'd2, 32'h22,    0, 5'd0,  1, 5'd11, 32'hA1,       32'h0,        2'd2, 0, 0);
        tbl[7]  = mk(1, 5'd12, 32'hA2,       1, 5'd3, 32'h33,    0, 5'd0,  1, 5'd12, 32'hA2,       32'h0,        2'd2, 0, 0);
        tbl[8]  = mk(1, 5'd13, 32'hA3,       1, 5'd3, 32'h33,    0, 5'd0,  1, 5'd13, 32'hA3,       32'h0,        2'd2, 0, 0);
        tbl[9]  = mk(1, 5'd14, 32'hA4,       1, 5'd3, 32'h33,    0, 5'd0,  1, 5'd14, 32'hA4,       32'h0,        2'd2, 0, 0);
        tbl[10] = mk(1, 5'd15, 32'hA5,       1, 5'd3, 32'h33,    0, 5'd0,  1, 5'd15, 32'hA5,       32'h0,        2'd2, 0, 0);
        tbl[11] = mk(0, 5'd0,  32'h0,        1, 5'd3, 32'h33,    0, 5'd0,  1, 5'd1,  32'h11,       32'h0,        2'd1, 1, 0);
        tbl[12] = mk(0, 5'd0,  32'h0,        1, 5'd3, 32'h33,    0, 5'd0,  1, 5'd2,  32'h22,       32'h0,        2'd1, 1, 0);
        tbl[13] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     0, 5'd0,  1, 5'd3,  32'h33,       32'h0,        2'd0, 1, 0);
        // register 0 writes are consumed but never assert rf_we
        tbl[14] = mk(1, 5'd0,  32'hFFFF,     0, 5'd0, 32'h0,     0, 5'd0,  0, 5'd0,  32'h0,        32'h0,        2'd0, 1, 0);
        tbl[15] = mk(0, 5'd0,  32'h0,        1, 5'd0, 32'h5,     0, 5'd0,  0, 5'd0,  32'h0,        32'h0,        2'd1, 1, 0);
        tbl[16] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     0, 5'd0,  0, 5'd0,  32'h0,        32'h0,        2'd0, 1, 0);
        tbl[17] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     1, 5'd0,  0, 5'd0,  32'h0,        32'h0,        2'd0, 1, 0);
        // set beats clear on the same index, then a re-issue is flagged
        tbl[18] = mk(1, 5'd0,  32'h1,        1, 5'd7, 32'h77,    0, 5'd0,  0, 5'd0,  32'h0,        32'h0,        2'd1, 1, 0);
        tbl[19] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     1, 5'd7,  1, 5'd7,  32'h77,       32'h00000080, 2'd0, 1, 0);
        tbl[20] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,     1, 5'd7,  0, 5'd0,  32'h0,        32'h00000080, 2'd0, 1, 1);
        tbl[21] = mk(1, 5'd20, 32'h1,        1, 5'd4, 32'h44,    1, 5'd2,  1, 5'd20, 32'h1,        32'h00000084, 2'd1, 1, 1);
        tbl[22] = mk(1, 5'd21, 32'h2,        1, 5'd5, 32'h55,    0, 5'd0,  1, 5'd21, 32'h2,        32'h00000084, 2'd2, 0, 1);

        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        #2;
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            tick();
            chk($sformatf("v%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].ewe));
            if (tbl[i].ewe) begin
                chk($sformatf("v%0d_wr", i), 32'(bus.rf_wr), 32'(tbl[i].ewr));
                chk($sformatf("v%0d_wd", i), bus.rf_wd, tbl[i].ewd);
            end
            chk($sformatf("v%0d_pending", i), bus.pending, tbl[i].epend);
            chk($sformatf("v%0d_count", i), 32'(bus.fifo_count), 32'(tbl[i].ecnt));
            chk($sformatf("v%0d_ready", i), 32'(bus.lng_ready), 32'(tbl[i].erdy));
            chk($sformatf("v%0d_err", i), 32'(bus.err_reissue), 32'(tbl[i].eerr));
        end

        // Mid-cycle reset with two entries queued: outputs clear without waiting for a clock edge.
        bus.lng_valid = 1'b0;
        bus.alu_wr    = 5'd22;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        idle();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset%0d_we", i), 32'(bus.rf_we), 32'd0);
            chk($sformatf("post_reset%0d_count", i), 32'(bus.fifo_count), 32'd0);
            chk($sformatf("post_reset%0d_pending", i), bus.pending, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
